// File: rtl/mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux_rr_scheduler
//
// Purpose:
//   Round-robin scheduler that shares one 8x1 mux datapath among 8
//   requesters. It drives the mux select and a one-hot grant. A grant is
//   held for at most HOLD_MAX accepted transfers, or until the granted
//   requester drops its request. Between consecutive grants there is always
//   exactly one IDLE cycle, which gives the mux time to settle.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  asynchronous, active-high reset
//   req    in   8  request per source; bit i = source i
//   ready  in   1  downstream accepts the current mux output this cycle
//   lock   in   1  (only with MUX_RR_SCHEDULER_LOCK_EN) suppresses the
//                  transfer-count release while high
//   sel    out  3  select for the 8x1 mux (index of granted source)
//   gnt    out  8  one-hot grant; all zero when no grant
//   valid  out  1  mux output is valid for the granted source
//   busy   out  1  high while a grant is active
//
// Parameters:
//   HOLD_MAX  maximum accepted transfers per grant, legal range 1..15
//   CNT_W     transfer counter width, 2**CNT_W must exceed HOLD_MAX
//
// Optional feature macro: MUX_RR_SCHEDULER_LOCK_EN
//   When defined, a `lock` input is added after `ready`. While lock is high
//   the count-based release is suppressed and the counter saturates at
//   HOLD_MAX-1; only a request drop ends the grant.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mux_rr_scheduler #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ready,
`ifdef MUX_RR_SCHEDULER_LOCK_EN
    input  logic       lock,
`endif
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Count value at which the next accepted transfer ends the grant.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(HOLD_MAX - 1);

    // Registered state and outputs.
    state_t           r_state;
    logic [2:0]       r_sel;
    logic [7:0]       r_gnt;
    logic             r_valid;
    logic             r_busy;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;

    // Next-state values.
    state_t           w_state_nx;
    logic [2:0]       w_sel_nx;
    logic [7:0]       w_gnt_nx;
    logic             w_valid_nx;
    logic             w_busy_nx;
    logic [2:0]       w_ptr_nx;
    logic [CNT_W-1:0] w_cnt_nx;

    // Arbitration and transfer qualifiers.
    logic             w_found;
    logic [2:0]       w_winner;
    logic             w_lock;
    logic             w_req_sel;
    logic             w_xfer;
    logic             w_cnt_last;
    logic             w_release;

`ifdef MUX_RR_SCHEDULER_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_req_sel  = req[r_sel];
    assign w_xfer     = r_valid & ready & w_req_sel;
    assign w_cnt_last = (r_cnt == LP_CNT_LAST);
    // A dropped request always ends the grant; the count limit only does so
    // when a transfer is accepted on the last allowed beat and lock is low.
    assign w_release  = (~w_req_sel) | (w_xfer & w_cnt_last & ~w_lock);

    // Round-robin search: first set request starting just after the last
    // granted index, wrapping modulo 8 so the last winner is checked last.
    always_comb begin
        logic [2:0] v_idx;
        w_found  = 1'b0;
        w_winner = 3'd0;
        v_idx    = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            v_idx = r_ptr + 3'(i);
            if (!w_found && req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Next-state and next-output logic of the IDLE/GRANT controller.
    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_gnt_nx   = r_gnt;
        w_valid_nx = r_valid;
        w_busy_nx  = r_busy;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nx = ST_GRANT;
                    w_sel_nx   = w_winner;
                    w_gnt_nx   = 8'b0000_0001 << w_winner;
                    w_valid_nx = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_ptr_nx   = w_winner;
                    w_cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    w_valid_nx = 1'b0;
                    w_gnt_nx   = 8'h00;
                    w_busy_nx  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // sel keeps its last value so the mux path stays stable
                    // through the gap cycle.
                    w_state_nx = ST_IDLE;
                    w_valid_nx = 1'b0;
                    w_gnt_nx   = 8'h00;
                    w_busy_nx  = 1'b0;
                end else if (w_xfer && !w_cnt_last) begin
                    w_cnt_nx = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    // Either no transfer, or a locked transfer at the last
                    // count: the counter saturates and everything holds.
                    w_cnt_nx = r_cnt;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_valid_nx = 1'b0;
                w_gnt_nx   = 8'h00;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset; ptr resets to 7 so
    // the first search after reset begins at source 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_gnt   <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= 3'd7;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_gnt   <= w_gnt_nx;
            r_valid <= w_valid_nx;
            r_busy  <= w_busy_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign sel   = r_sel;
    assign gnt   = r_gnt;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_scheduler
//
// Self-checking bench for mux_rr_scheduler. A behavioural model tracks the
// active grant (source, accepted-transfer total, last winner) and predicts
// sel/gnt/valid/busy after every rising edge. Directed sections follow the
// scheduler's key scenarios, then a randomized run with occasional
// asynchronous resets exercises the general case.
// -----------------------------------------------------------------------------
module tb_mux_rr_scheduler;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic       lock_v;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       valid;
    logic       busy;

    int n_checks;
    int n_errors;

    // Behavioural model state.
    bit  m_gr;
    int  m_sel;
    int  m_ptr;
    int  m_xfers;

    // Observed grant order (sel captured whenever valid rises).
    int  g_order[$];
    bit  prev_valid;

    mux_rr_scheduler #(
        .HOLD_MAX (HOLD),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
`ifdef MUX_RR_SCHEDULER_LOCK_EN
        .lock  (lock_v),
`endif
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gr       = 1'b0;
        m_sel      = 0;
        m_ptr      = 7;
        m_xfers    = 0;
        prev_valid = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        bit found;
        int s;
        if (m_gr) begin
            if (!req[m_sel]) begin
                m_gr = 1'b0;
            end else if (ready) begin
                m_xfers++;
                if (m_xfers >= HOLD && !lock_v) m_gr = 1'b0;
            end
        end else if (req != 8'h00) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                s = (m_ptr + k) % 8;
                if (!found && req[s]) begin
                    found   = 1'b1;
                    m_sel   = s;
                    m_ptr   = s;
                    m_gr    = 1'b1;
                    m_xfers = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] exp_gnt;
        exp_gnt = m_gr ? (8'h01 << m_sel) : 8'h00;
        chk({tag, "_sel"},   {5'd0, sel},   8'(m_sel));
        chk({tag, "_gnt"},   gnt,           exp_gnt);
        chk({tag, "_valid"}, {7'd0, valid}, {7'd0, m_gr});
        chk({tag, "_busy"},  {7'd0, busy},  {7'd0, m_gr});
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        if (valid && !prev_valid) g_order.push_back(int'(sel));
        prev_valid = valid;
    endtask

    // Assert reset between edges, check outputs drop at once, release at negedge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_rgnt"},   gnt,           8'h00);
        chk({tag, "_rvalid"}, {7'd0, valid}, 8'h00);
        chk({tag, "_rbusy"},  {7'd0, busy},  8'h00);
        chk({tag, "_rsel"},   {5'd0, sel},   8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit         bp[7];
        int         nq;
        logic [31:0] r;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req      = 8'h00;
        ready    = 1'b0;
        lock_v   = 1'b0;
        model_reset();

        // Power-on reset state.
        #12;
        check_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-grant, then first grant after reset goes to source 0.
        req = 8'h04;
        tick("rst_a");
        chk("rst_gnt04", gnt, 8'h04);
        tick("rst_b");
        async_reset("rst_mid");
        req = 8'h01;
        tick("rst_c");
        chk("rst_sel0", {5'd0, sel}, 8'h00);
        chk("rst_gnt01", gnt, 8'h01);

        // Round-robin fairness with all sources requesting.
        async_reset("fair");
        req   = 8'hFF;
        ready = 1'b1;
        g_order.delete();
        for (int i = 0; i < 45; i++) tick("fair");
        chk("fair_n", 8'(g_order.size()), 8'd9);
        for (int i = 0; i < 9; i++) begin
            nq = (i < g_order.size()) ? g_order[i] : 255;
            chk("fair_order", 8'(nq), 8'(i % 8));
        end

        // Request drop after two transfers, then source 7 next.
        async_reset("drop");
        req   = 8'h08;
        ready = 1'b1;
        tick("drop");
        chk("drop_gnt3", gnt, 8'h08);
        tick("drop");
        tick("drop");
        req = 8'h80;
        tick("drop");
        chk("drop_rel", {7'd0, valid}, 8'h00);
        chk("drop_selheld", {5'd0, sel}, 8'd3);
        tick("drop");
        chk("drop_next7", gnt, 8'h80);

        // Backpressure: release only after the 4th accepted transfer.
        async_reset("bp");
        req   = 8'h20;
        ready = 1'b0;
        tick("bp");
        chk("bp_gnt5", gnt, 8'h20);
        bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            ready = bp[i];
            tick("bp");
            chk("bp_valid", {7'd0, valid}, (i < 6) ? 8'd1 : 8'd0);
        end

        // Wrap with sparse requests: 6, then 0 (search 7,0), then 6.
        async_reset("wrap");
        req   = 8'h40;
        ready = 1'b1;
        g_order.delete();
        tick("wrap");
        req = 8'h41;
        for (int i = 0; i < 13; i++) tick("wrap");
        chk("wrap_n", 8'(g_order.size()), 8'd3);
        for (int i = 0; i < 3; i++) begin
            nq = (i < g_order.size()) ? g_order[i] : 255;
            chk("wrap_order", 8'(nq), (i == 1) ? 8'd0 : 8'd6);
        end

`ifdef MUX_RR_SCHEDULER_LOCK_EN
        // Lock keeps the grant past HOLD transfers; unlock releases on next transfer.
        async_reset("lock");
        lock_v = 1'b1;
        req    = 8'h04;
        ready  = 1'b1;
        tick("lock");
        for (int i = 0; i < 10; i++) begin
            tick("lock");
            chk("lock_hold", gnt, 8'h04);
        end
        lock_v = 1'b0;
        tick("lock");
        chk("lock_rel", {7'd0, valid}, 8'h00);
        tick("lock");
`endif

        // Randomized traffic against the model, with occasional resets.
        async_reset("rnd");
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            if (r[1:0] == 2'd0) req = r[15:8] & r[23:16];
            ready = (r[26:25] != 2'd0);
`ifdef MUX_RR_SCHEDULER_LOCK_EN
            if (r[30:28] == 3'd0) lock_v = ~lock_v;
`endif
            if (r[31] && r[7:2] == 6'd0) async_reset("rnd");
            else tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
